// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared widths, owner ids and FSM state type for mem_arbiter
package mem_arb_pkg;
  localparam int DATA_W = 16;
  localparam int ADDR_W = 16;
  localparam logic OWN_A = 1'b0;
  localparam logic OWN_B = 1'b1;
  typedef enum logic [1:0] {ST_IDLE, ST_ACCESS, ST_RESP} state_t;
endpackage

// File: rtl/rr_picker.sv
// rr_picker: two-way round-robin winner select, owns the last_owner register
module rr_picker
  import mem_arb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req_a,
  input  logic req_b,
  input  logic update,
  output logic valid,
  output logic pick
);
  logic last_owner;
  always_ff @(posedge clk) begin
    if (rst) last_owner <= OWN_B;
    else if (update) last_owner <= pick;
  end
  always_comb begin
    valid = req_a | req_b;
    pick = (req_a & req_b) ? ~last_owner : (req_b ? OWN_B : OWN_A);
  end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: round-robin sharing of a single-port memory between ports A and B
module mem_arbiter #(
  parameter int DATA_W = mem_arb_pkg::DATA_W,
  parameter int ADDR_W = mem_arb_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_req,
  input  logic              a_we,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic              a_ack,
  output logic [DATA_W-1:0] a_rdata,
  input  logic              b_req,
  input  logic              b_we,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic              b_ack,
  output logic [DATA_W-1:0] b_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_in,
  input  logic [DATA_W-1:0] mem_out
);
  import mem_arb_pkg::*;
  state_t state, state_nx;
  logic owner, cmd_we, valid, pick, start;
  logic [ADDR_W-1:0] cmd_addr;
  logic [DATA_W-1:0] cmd_wdata, a_rdata_q, b_rdata_q;
  rr_picker u_pick (
    .clk    (clk),
    .rst    (rst),
    .req_a  (a_req),
    .req_b  (b_req),
    .update (start),
    .valid  (valid),
    .pick   (pick)
  );
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else state <= state_nx;
  end
  always_comb begin
    start = (state == ST_IDLE) & valid;
    state_nx = start ? ST_ACCESS : (state == ST_ACCESS) ? ST_RESP : ST_IDLE;
    a_ack = (state == ST_RESP) & (owner == OWN_A) & ~rst;
    b_ack = (state == ST_RESP) & (owner == OWN_B) & ~rst;
    a_rdata = (a_ack & ~cmd_we) ? mem_out : a_rdata_q;
    b_rdata = (b_ack & ~cmd_we) ? mem_out : b_rdata_q;
    mem_we = (state == ST_ACCESS) & cmd_we & ~rst;
    mem_addr = cmd_addr;
    mem_in = cmd_wdata;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      owner <= OWN_A;
      cmd_we <= 1'b0;
      cmd_addr <= '0;
      cmd_wdata <= '0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
    end else begin
      if (start) begin
        owner <= pick;
        cmd_we <= pick ? b_we : a_we;
        cmd_addr <= pick ? b_addr : a_addr;
        cmd_wdata <= pick ? b_wdata : a_wdata;
      end
      if (a_ack & ~cmd_we) a_rdata_q <= mem_out;
      if (b_ack & ~cmd_we) b_rdata_q <= mem_out;
    end
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: scoreboard bench for mem_arbiter with a behavioural memory
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic a_req = 1'b0, a_we = 1'b0, b_req = 1'b0, b_we = 1'b0;
  logic [15:0] a_addr = '0, a_wdata = '0, b_addr = '0, b_wdata = '0;
  logic a_ack, b_ack, mem_we;
  logic [15:0] a_rdata, b_rdata, mem_addr, mem_in, mem_out;
  logic [15:0] mem [0:127];
  logic [15:0] model_rd [2];
  int cyc = 0;
  int total = 0;
  int bad = 0;
  typedef struct {
    logic        port;
    int          cyc;
    logic [15:0] rd;
  } exp_t;
  exp_t sbq[$];
  mem_arbiter dut (
    .clk      (clk),
    .rst      (rst),
    .a_req    (a_req),
    .a_we     (a_we),
    .a_addr   (a_addr),
    .a_wdata  (a_wdata),
    .a_ack    (a_ack),
    .a_rdata  (a_rdata),
    .b_req    (b_req),
    .b_we     (b_we),
    .b_addr   (b_addr),
    .b_wdata  (b_wdata),
    .b_ack    (b_ack),
    .b_rdata  (b_rdata),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_in   (mem_in),
    .mem_out  (mem_out)
  );
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    if (mem_we) mem[mem_addr[7:1]] <= mem_in;
    mem_out <= mem[mem_addr[7:1]];
  end
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask
  task automatic push(input logic port, input int dly, input logic rd, input logic [15:0] d);
    if (rd) model_rd[port] = d;
    sbq.push_back('{port, cyc + dly, model_rd[port]});
  endtask
  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      if (a_ack | b_ack) begin
        chk("single_ack", {31'd0, a_ack & b_ack}, 32'd0);
        chk("ack_expected", {31'd0, sbq.size() != 0}, 32'd1);
        if (sbq.size() != 0) begin
          e = sbq.pop_front();
          chk("ack_port", {31'd0, b_ack}, {31'd0, e.port});
          chk("ack_cycle", cyc, e.cyc);
          chk("ack_rdata", {16'd0, e.port ? b_rdata : a_rdata}, {16'd0, e.rd});
        end
      end
    end
  endtask
  task automatic wait_ack(input logic port);
    logic seen;
    seen = 1'b0;
    for (int i = 0; i < 8 && !seen; i++) begin
      @(negedge clk);
      seen = port ? b_ack : a_ack;
    end
    chk(port ? "b_ack_seen" : "a_ack_seen", {31'd0, seen}, 32'd1);
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    model_rd[0] = '0;
    model_rd[1] = '0;
  endtask
  initial begin
    fork
      monitor();
    join_none
    model_rd[0] = '0;
    model_rd[1] = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_a_ack", {31'd0, a_ack}, 32'd0);
    chk("rst_b_ack", {31'd0, b_ack}, 32'd0);
    chk("rst_mem_we", {31'd0, mem_we}, 32'd0);
    chk("rst_mem_addr", {16'd0, mem_addr}, 32'd0);
    chk("rst_mem_in", {16'd0, mem_in}, 32'd0);
    chk("rst_a_rdata", {16'd0, a_rdata}, 32'd0);
    chk("rst_b_rdata", {16'd0, b_rdata}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    a_req = 1'b1; a_we = 1'b1; a_addr = 16'h0004; a_wdata = 16'hF10A;
    push(1'b0, 2, 1'b0, 16'h0);
    @(negedge clk);
    chk("wr_idle_we", {31'd0, mem_we}, 32'd0);
    @(negedge clk);
    chk("wr_acc_we", {31'd0, mem_we}, 32'd1);
    chk("wr_acc_addr", {16'd0, mem_addr}, 32'h0004);
    chk("wr_acc_in", {16'd0, mem_in}, 32'hF10A);
    @(negedge clk);
    chk("wr_resp_we", {31'd0, mem_we}, 32'd0);
    @(posedge clk);
    #1;
    a_req = 1'b0;
    chk("wr_mem2", {16'd0, mem[2]}, 32'hF10A);
    b_req = 1'b1; b_we = 1'b1; b_addr = 16'h000A; b_wdata = 16'hD102;
    push(1'b1, 2, 1'b0, 16'h0);
    wait_ack(1'b1);
    b_req = 1'b0;
    a_req = 1'b1; a_we = 1'b1; a_addr = 16'h0006; a_wdata = 16'h5555;
    push(1'b0, 2, 1'b0, 16'h0);
    wait_ack(1'b0);
    a_we = 1'b0; a_addr = 16'h000A;
    push(1'b0, 2, 1'b1, 16'hD102);
    wait_ack(1'b0);
    a_req = 1'b0;
    @(negedge clk);
    chk("rd_hold_a", {16'd0, a_rdata}, 32'hD102);
    chk("rd_b_quiet", {31'd0, b_ack}, 32'd0);
    chk("rd_b_rdata", {16'd0, b_rdata}, 32'd0);
    do_reset();
    a_req = 1'b1; a_we = 1'b1; a_addr = 16'h0002; a_wdata = 16'h0001;
    b_req = 1'b1; b_we = 1'b1; b_addr = 16'h0002; b_wdata = 16'h0002;
    push(1'b0, 2, 1'b0, 16'h0);
    push(1'b1, 5, 1'b0, 16'h0);
    wait_ack(1'b0);
    a_req = 1'b0;
    wait_ack(1'b1);
    b_req = 1'b0;
    chk("tie_mem1", {16'd0, mem[1]}, 32'h0002);
    a_we = 1'b0; a_addr = 16'h000A; b_we = 1'b0; b_addr = 16'h0002;
    a_req = 1'b1; b_req = 1'b1;
    push(1'b0, 2, 1'b1, 16'hD102);
    push(1'b1, 5, 1'b1, 16'h0002);
    push(1'b0, 8, 1'b1, 16'hD102);
    push(1'b1, 11, 1'b1, 16'h0002);
    for (int k = 0; k < 4; k++) wait_ack(k % 2 == 1);
    a_req = 1'b0; b_req = 1'b0;
    b_we = 1'b1; b_addr = 16'h0006; b_wdata = 16'h1234; b_req = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    chk("rst_acc_we", {31'd0, mem_we}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0; b_req = 1'b0;
    model_rd[0] = '0;
    model_rd[1] = '0;
    a_we = 1'b0; a_addr = 16'h0006; a_req = 1'b1;
    push(1'b0, 2, 1'b1, 16'h5555);
    @(negedge clk);
    chk("rst_no_b_ack", {31'd0, b_ack}, 32'd0);
    chk("rst_mem3", {16'd0, mem[3]}, 32'h5555);
    wait_ack(1'b0);
    a_addr = 16'h000A;
    push(1'b0, 2, 1'b1, 16'hD102);
    push(1'b0, 5, 1'b1, 16'h0002);
    wait_ack(1'b0);
    a_addr = 16'h0002;
    wait_ack(1'b0);
    a_req = 1'b0;
    @(negedge clk);
    chk("b2b_hold", {16'd0, a_rdata}, 32'h0002);
    chk("sb_drained", sbq.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
